// File: rtl/dlfloat_pkg.sv
// dlfloat_pkg: shared DLFloat16 constants, serializer state type and the
// optional result classifier. The classifier exists only when
// DLF_RESULT_CLASS_EN is defined.
package dlfloat_pkg;

    localparam int DLF_W        = 16;
    localparam int DLF_EXP_W    = 6;
    localparam int DLF_MAN_W    = 9;
    localparam int DLF_EXP_BIAS = 31;
    localparam logic [DLF_EXP_W-1:0] DLF_EXP_MAX = 6'h3F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2
    } ser_state_t;

`ifdef DLF_RESULT_CLASS_EN
    localparam logic [1:0] DLF_CLS_NORMAL = 2'b00;
    localparam logic [1:0] DLF_CLS_ZERO   = 2'b01;
    localparam logic [1:0] DLF_CLS_SAT    = 2'b10;
    localparam logic [1:0] DLF_CLS_SUBN   = 2'b11;

    // Zero wins over the exponent tests so that +/-0 is never reported as subnormal.
    function automatic logic [1:0] dlf_classify(input logic [DLF_W-1:0] word);
        logic [DLF_EXP_W-1:0] expField;
        expField = word[DLF_W-2 -: DLF_EXP_W];
        if (word[DLF_W-2:0] == '0)
            return DLF_CLS_ZERO;
        else if (expField == DLF_EXP_MAX)
            return DLF_CLS_SAT;
        else if (expField == '0)
            return DLF_CLS_SUBN;
        else
            return DLF_CLS_NORMAL;
    endfunction
`endif

endpackage

// File: rtl/dlfloat_sync_fifo.sv
// dlfloat_sync_fifo: single-clock FIFO. Pop on empty is ignored; a push
// while full is taken only when a pop happens in the same cycle.
module dlfloat_sync_fifo #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [WIDTH-1:0]  data_i,
    output logic [WIDTH-1:0]  head_o,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wrPtr_q;
    logic [ADDR_W-1:0] rdPtr_q;
    logic [ADDR_W:0]   count_q;
    logic              popEn;
    logic              pushEn;

    assign popEn   = pop_i && (count_q != '0);
    assign pushEn  = push_i && ((count_q != DEPTH_CNT) || popEn);
    assign head_o  = mem_q[rdPtr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == DEPTH_CNT);
    assign empty_o = (count_q == '0);

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (pushEn)
            mem_q[wrPtr_q] <= data_i;
    end

    // Pointers wrap naturally at DEPTH; count moves only on unbalanced push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (pushEn)
                wrPtr_q <= wrPtr_q + 1'b1;
            if (popEn)
                rdPtr_q <= rdPtr_q + 1'b1;
            if (pushEn && !popEn)
                count_q <= count_q + 1'b1;
            else if (popEn && !pushEn)
                count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/dlfloat_result_serializer.sv
// dlfloat_result_serializer: buffers DLFloat16 MAC results and streams each
// one as two bytes (high first) over a valid/ready byte port. Results that
// arrive when the buffer is full are dropped and counted.
// Optional: DLF_RESULT_CLASS_EN adds a per-word class carried out on cls_o.
module dlfloat_result_serializer
    import dlfloat_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    input  logic [15:0]       res_data_i,
    input  logic              out_ready_i,
    output logic [7:0]        byte_out_o,
    output logic              byte_valid_o,
    output logic              byte_hi_o,
    output logic [ADDR_W:0]   fifo_count_o,
    output logic              ovf_o,
    output logic [CNT_W-1:0]  drop_cnt_o
`ifdef DLF_RESULT_CLASS_EN
    ,
    output logic [1:0]        cls_o
`endif
);

`ifdef DLF_RESULT_CLASS_EN
    localparam int ENTRY_W = DLF_W + 2;
`else
    localparam int ENTRY_W = DLF_W;
`endif

    ser_state_t         state_q, state_d;
    logic [ENTRY_W-1:0] hold_q, hold_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   dropCnt_q, dropCnt_d;

    logic [ENTRY_W-1:0] pushEntry;
    logic [ENTRY_W-1:0] fifoHead;
    logic [ADDR_W:0]    fifoCount;
    logic               fifoFull;
    logic               fifoEmpty;
    logic               pop;
    logic               drop;
    logic [7:0]         byteOut;
    logic               byteValid;
    logic               byteHi;

`ifdef DLF_RESULT_CLASS_EN
    assign pushEntry = {dlf_classify(res_data_i), res_data_i};
    assign cls_o     = hold_q[ENTRY_W-1 -: 2];
`else
    assign pushEntry = res_data_i;
`endif

    dlfloat_sync_fifo #(
        .WIDTH  (ENTRY_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid_i),
        .pop_i   (pop),
        .data_i  (pushEntry),
        .head_o  (fifoHead),
        .count_o (fifoCount),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    // Serializer next state: fetch a word, show its high byte, then its low byte.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        pop       = 1'b0;
        byteOut   = 8'h00;
        byteValid = 1'b0;
        byteHi    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifoEmpty) begin
                    hold_d  = fifoHead;
                    pop     = 1'b1;
                    state_d = HI;
                end
            end
            HI: begin
                byteOut   = hold_q[15:8];
                byteValid = 1'b1;
                byteHi    = 1'b1;
                if (out_ready_i)
                    state_d = LO;
            end
            LO: begin
                byteOut   = hold_q[7:0];
                byteValid = 1'b1;
                if (out_ready_i) begin
                    if (!fifoEmpty) begin
                        hold_d  = fifoHead;
                        pop     = 1'b1;
                        state_d = HI;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A result is lost only when the FIFO is full and no slot frees this cycle.
    always_comb begin
        drop      = in_valid_i && fifoFull && !pop;
        ovf_d     = ovf_q;
        dropCnt_d = dropCnt_q;
        if (drop) begin
            ovf_d = 1'b1;
            if (dropCnt_q != '1)
                dropCnt_d = dropCnt_q + 1'b1;
        end
    end

    // State, held word and overflow bookkeeping; reset also discards any partial word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            ovf_q     <= 1'b0;
            dropCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            ovf_q     <= ovf_d;
            dropCnt_q <= dropCnt_d;
        end
    end

    assign byte_out_o   = byteOut;
    assign byte_valid_o = byteValid;
    assign byte_hi_o    = byteHi;
    assign fifo_count_o = fifoCount;
    assign ovf_o        = ovf_q;
    assign drop_cnt_o   = dropCnt_q;

endmodule

// File: tb/tb_dlfloat_result_serializer.sv
// tb_dlfloat_result_serializer: directed scenarios plus randomized traffic,
// compared against a queue-based reference model of the serializer.
// Define DLF_RESULT_CLASS_EN to also exercise the cls_o output.
module tb_dlfloat_result_serializer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int CNT_W  = 8;
    localparam int DROP_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid_i = 1'b0;
    logic [15:0]       res_data_i = 16'h0000;
    logic              out_ready_i = 1'b0;
    logic [7:0]        byte_out_o;
    logic              byte_valid_o;
    logic              byte_hi_o;
    logic [ADDR_W:0]   fifo_count_o;
    logic              ovf_o;
    logic [CNT_W-1:0]  drop_cnt_o;
`ifdef DLF_RESULT_CLASS_EN
    logic [1:0]        cls_o;
`endif

    int compareCount  = 0;
    int mismatchCount = 0;

    logic [15:0] refQueue[$];
    logic        refBusy;
    logic        refLowPhase;
    logic [15:0] refWord;
    logic        refOvf;
    int          refDrops;

    dlfloat_result_serializer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid_i   (in_valid_i),
        .res_data_i   (res_data_i),
        .out_ready_i  (out_ready_i),
        .byte_out_o   (byte_out_o),
        .byte_valid_o (byte_valid_o),
        .byte_hi_o    (byte_hi_o),
        .fifo_count_o (fifo_count_o),
        .ovf_o        (ovf_o),
        .drop_cnt_o   (drop_cnt_o)
`ifdef DLF_RESULT_CLASS_EN
        ,
        .cls_o        (cls_o)
`endif
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [1:0] refClass(input logic [15:0] w);
        if (w[14:0] == 15'd0)       return 2'b01;
        else if (w[14:9] == 6'h3F)  return 2'b10;
        else if (w[14:9] == 6'h00)  return 2'b11;
        else                        return 2'b00;
    endfunction

    task automatic modelReset();
        refQueue.delete();
        refBusy     = 1'b0;
        refLowPhase = 1'b0;
        refWord     = 16'h0000;
        refOvf      = 1'b0;
        refDrops    = 0;
    endtask

    // One clock edge of the reference: byte transfer first, then the new result.
    task automatic modelEdge(input logic v, input logic [15:0] d, input logic r);
        if (!refBusy) begin
            if (refQueue.size() > 0) begin
                refWord     = refQueue.pop_front();
                refBusy     = 1'b1;
                refLowPhase = 1'b0;
            end
        end else if (r) begin
            if (!refLowPhase) begin
                refLowPhase = 1'b1;
            end else if (refQueue.size() > 0) begin
                refWord     = refQueue.pop_front();
                refLowPhase = 1'b0;
            end else begin
                refBusy = 1'b0;
            end
        end
        if (v) begin
            if (refQueue.size() < DEPTH) begin
                refQueue.push_back(d);
            end else begin
                refOvf = 1'b1;
                if (refDrops < DROP_MAX)
                    refDrops++;
            end
        end
    endtask

    task automatic checkAgainstModel();
        checkOutput("byte_valid", 32'(byte_valid_o), 32'(refBusy));
        if (refBusy) begin
            checkOutput("byte_out", 32'(byte_out_o),
                        32'(refLowPhase ? refWord[7:0] : refWord[15:8]));
            checkOutput("byte_hi", 32'(byte_hi_o), 32'(!refLowPhase));
`ifdef DLF_RESULT_CLASS_EN
            checkOutput("cls", 32'(cls_o), 32'(refClass(refWord)));
`endif
        end
        checkOutput("fifo_count", 32'(fifo_count_o), 32'(refQueue.size()));
        checkOutput("ovf", 32'(ovf_o), 32'(refOvf));
        checkOutput("drop_cnt", 32'(drop_cnt_o), 32'(refDrops));
    endtask

    // Drive one cycle of inputs from a negedge, advance the model, check at the next negedge.
    task automatic applyStimulus(input logic v, input logic [15:0] d, input logic r);
        in_valid_i  = v;
        res_data_i  = d;
        out_ready_i = r;
        @(posedge clk);
        modelEdge(v, d, r);
        @(negedge clk);
        checkAgainstModel();
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic applyReset();
        in_valid_i  = 1'b0;
        res_data_i  = 16'h0000;
        out_ready_i = 1'b0;
        rst = 1'b0;
        #1;
        modelReset();
        checkAgainstModel();
        checkOutput("rst_byte_out", 32'(byte_out_o), 32'h0);
        checkOutput("rst_byte_hi", 32'(byte_hi_o), 32'h0);
`ifdef DLF_RESULT_CLASS_EN
        checkOutput("rst_cls", 32'(cls_o), 32'h0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [15:0] randomWord();
        logic [15:0] w;
        w = 16'($urandom);
        case ($urandom_range(0, 3))
            0: w = w & 16'h8000;
            1: w = w | 16'h7E00;
            2: w = w & 16'h81FF;
            default: ;
        endcase
        return w;
    endfunction

`ifdef DLF_RESULT_CLASS_EN
    logic [15:0] clsWords [4] = '{16'h0000, 16'h7E00, 16'h0005, 16'h3E00};
    logic [1:0]  clsExpect[4] = '{2'b01, 2'b10, 2'b11, 2'b00};
`endif

    initial begin
        modelReset();
        @(negedge clk);
        applyReset();

        $display("[TB] single word with free-flowing consumer");
        applyStimulus(1'b1, 16'hA5C3, 1'b1);
        checkOutput("t1_count_after_push", 32'(fifo_count_o), 32'd1);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("t1_hi_byte", 32'(byte_out_o), 32'hA5);
        checkOutput("t1_hi_flag", 32'(byte_hi_o), 32'h1);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("t1_lo_byte", 32'(byte_out_o), 32'hC3);
        checkOutput("t1_lo_flag", 32'(byte_hi_o), 32'h0);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("t1_idle_valid", 32'(byte_valid_o), 32'h0);

        $display("[TB] backpressure holds the high byte");
        applyStimulus(1'b1, 16'h1234, 1'b0);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, 16'h0000, 1'b0);
        checkOutput("t2_held_byte", 32'(byte_out_o), 32'h12);
        checkOutput("t2_held_valid", 32'(byte_valid_o), 32'h1);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("t2_lo_byte", 32'(byte_out_o), 32'h34);
        applyStimulus(1'b0, 16'h0000, 1'b1);

        $display("[TB] overflow with stalled consumer");
        for (int i = 1; i <= 6; i++)
            applyStimulus(1'b1, 16'(16'h1000 + i), 1'b0);
        checkOutput("t3_ovf", 32'(ovf_o), 32'h1);
        checkOutput("t3_drop_cnt", 32'(drop_cnt_o), 32'd1);
        checkOutput("t3_count_full", 32'(fifo_count_o), 32'd4);
        for (int i = 0; i < 12; i++)
            applyStimulus(1'b0, 16'h0000, 1'b1);

        $display("[TB] full FIFO with simultaneous push and pop");
        @(negedge clk);
        applyReset();
        for (int i = 1; i <= 5; i++)
            applyStimulus(1'b1, 16'(16'h2000 + i), 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        applyStimulus(1'b1, 16'hBEEF, 1'b1);
        checkOutput("t4_count_kept", 32'(fifo_count_o), 32'd4);
        checkOutput("t4_ovf_clear", 32'(ovf_o), 32'h0);
        checkOutput("t4_next_word_hi", 32'(byte_out_o), 32'h20);

        $display("[TB] reset in low phase with buffered words");
        applyStimulus(1'b0, 16'h0000, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("t5_pre_count", 32'(fifo_count_o), 32'd3);
        checkOutput("t5_pre_lo", 32'(byte_hi_o), 32'h0);
        applyReset();
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b0, 16'h0000, 1'b1);

`ifdef DLF_RESULT_CLASS_EN
        $display("[TB] result classes");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, clsWords[i], 1'b1);
            applyStimulus(1'b0, 16'h0000, 1'b1);
            checkOutput("t6_cls", 32'(cls_o), 32'(clsExpect[i]));
            applyStimulus(1'b0, 16'h0000, 1'b1);
            applyStimulus(1'b0, 16'h0000, 1'b1);
        end
`endif

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++)
            applyStimulus($urandom_range(0, 99) < 60, randomWord(),
                          $urandom_range(0, 99) < 50);
        for (int i = 0; i < 12; i++)
            applyStimulus(1'b0, 16'h0000, 1'b1);

        $display("[TB] drop counter saturation");
        applyReset();
        for (int i = 0; i < 270; i++)
            applyStimulus(1'b1, randomWord(), 1'b0);
        checkOutput("sat_drop_cnt", 32'(drop_cnt_o), 32'(DROP_MAX));
        for (int i = 0; i < 12; i++)
            applyStimulus(1'b0, 16'h0000, 1'b1);
        applyReset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
